// File: rtl/vga_text_pkg.sv
// Shared constants, state encoding and address helpers for the VGA text writer.
package vga_text_pkg;

  localparam int COLS        = 64;
  localparam int ROWS        = 30;
  localparam int CLEAR_WORDS = COLS * ROWS;

  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] FF    = 8'h0C;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    CLEAR_ROW = 2'd2,
    CLEAR_ALL = 2'd3
  } state_e;

  // Ring-buffer row translation: 6-bit add then one conditional subtract.
  function automatic logic [4:0] phys_row(input logic [4:0] base, input logic [4:0] row);
    logic [5:0] sum;
    sum = {1'b0, base} + {1'b0, row};
    if (sum >= 6'(ROWS)) sum = sum - 6'(ROWS);
    return sum[4:0];
  endfunction

  // RAM cell address = phys_row*64 + col; top bit never set.
  function automatic logic [11:0] cell_addr(input logic [4:0] prow, input logic [5:0] col);
    return {1'b0, prow, col};
  endfunction

  function automatic logic is_print(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/vga_cursor_blink.sv
// Cursor blink timer: toggles visibility every BLINK_CYCLES clocks, restarts
// visible on each accepted byte, and is masked whenever the writer is busy.
module vga_cursor_blink #(
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic idle,
  output logic vis
);
  localparam int CW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          vis_q, vis_d;

  // Next-state for the half-period counter and the visibility phase.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    vis_d = vis_q;
    if (restart) begin
      cnt_d = '0;
      vis_d = 1'b1;
    end else if (cnt_q == CW'(BLINK_CYCLES - 1)) begin
      cnt_d = '0;
      vis_d = ~vis_q;
    end
  end

  // Counter and phase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      vis_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      vis_q <= vis_d;
    end
  end

  assign vis = idle & vis_q;

endmodule

// File: rtl/vga_text_ctrl.sv
// Terminal-style writer for the 64x30 character RAM behind the VGA text renderer.
// Handles printable bytes, LF/CR/BS/FF, and ring-buffer scrolling via scroll_row.
// Optional build macro CURSOR_BLINK_EN enables a blinking cursor.
module vga_text_ctrl #(
  parameter int COLS = vga_text_pkg::COLS,
  parameter int ROWS = vga_text_pkg::ROWS
`ifdef CURSOR_BLINK_EN
  , parameter int BLINK_CYCLES = 25000000
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  ch,
  output logic        ram_we,
  output logic [11:0] ram_waddr,
  output logic [7:0]  ram_wdata,
  output logic [4:0]  scroll_row,
  output logic [4:0]  cur_row,
  output logic [5:0]  cur_col,
  output logic        cursor_vis
);
  import vga_text_pkg::*;

  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  state_e      state_q, state_d;
  logic [7:0]  ch_q, ch_d;
  logic        we_q, we_d;
  logic [11:0] waddr_q, waddr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [4:0]  scroll_q, scroll_d;
  logic [4:0]  row_q, row_d;
  logic [5:0]  col_q, col_d;

  logic        xfer;
  logic        nl;
  logic        bs_move;
  logic [4:0]  bs_row;
  logic [5:0]  bs_col;

  assign wr_ready = (state_q == IDLE);
  assign xfer     = wr_valid && wr_ready;

  // Backspace target: step left, or to the end of the previous row.
  assign bs_move = (col_q != '0) || (row_q != '0);
  assign bs_row  = (col_q != '0) ? row_q : row_q - 5'd1;
  assign bs_col  = (col_q != '0) ? col_q - 6'd1 : LAST_COL;

  // Sequencer: the write for a byte is registered on its transfer edge; cursor,
  // scroll and any follow-on row clear are resolved on the edge leaving WRITE.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    scroll_d = scroll_q;
    row_d    = row_q;
    col_d    = col_q;
    nl       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          ch_d    = ch;
          state_d = WRITE;
          if (is_print(ch)) begin
            we_d    = 1'b1;
            waddr_d = cell_addr(phys_row(scroll_q, row_q), col_q);
            wdata_d = ch;
          end else if (ch == BS && bs_move) begin
            we_d    = 1'b1;
            waddr_d = cell_addr(phys_row(scroll_q, bs_row), bs_col);
            wdata_d = SPACE;
          end else if (ch == FF) begin
            state_d = CLEAR_ALL;
            we_d    = 1'b1;
            waddr_d = '0;
            wdata_d = SPACE;
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
        if (is_print(ch_q)) begin
          if (col_q == LAST_COL) begin
            col_d = '0;
            nl    = 1'b1;
          end else begin
            col_d = col_q + 6'd1;
          end
        end else if (ch_q == LF) begin
          col_d = '0;
          nl    = 1'b1;
        end else if (ch_q == CR) begin
          col_d = '0;
        end else if (ch_q == BS && bs_move) begin
          row_d = bs_row;
          col_d = bs_col;
        end
        if (nl) begin
          if (row_q != LAST_ROW) begin
            row_d = row_q + 5'd1;
          end else begin
            // Old top row becomes the new bottom row and is blanked.
            scroll_d = (scroll_q == LAST_ROW) ? 5'd0 : scroll_q + 5'd1;
            state_d  = CLEAR_ROW;
            we_d     = 1'b1;
            waddr_d  = cell_addr(scroll_q, 6'd0);
            wdata_d  = SPACE;
          end
        end
      end
      CLEAR_ROW: begin
        if (waddr_q[5:0] == LAST_COL) begin
          state_d = IDLE;
        end else begin
          we_d    = 1'b1;
          waddr_d = waddr_q + 12'd1;
        end
      end
      CLEAR_ALL: begin
        if (!we_q) begin
          // Entered from reset: first write has not been issued yet.
          we_d    = 1'b1;
          waddr_d = '0;
          wdata_d = SPACE;
        end else if (waddr_q == 12'(CLEAR_WORDS - 1)) begin
          state_d  = IDLE;
          scroll_d = '0;
          row_d    = '0;
          col_d    = '0;
        end else begin
          we_d    = 1'b1;
          waddr_d = waddr_q + 12'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, cursor and registered RAM-port flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CLEAR_ALL;
      ch_q     <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= SPACE;
      scroll_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      scroll_q <= scroll_d;
      row_q    <= row_d;
      col_q    <= col_d;
    end
  end

  assign ram_we     = we_q;
  assign ram_waddr  = waddr_q;
  assign ram_wdata  = wdata_q;
  assign scroll_row = scroll_q;
  assign cur_row    = row_q;
  assign cur_col    = col_q;

`ifdef CURSOR_BLINK_EN
  vga_cursor_blink #(.BLINK_CYCLES(BLINK_CYCLES)) u_blink (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (xfer),
    .idle    (state_q == IDLE),
    .vis     (cursor_vis)
  );
`else
  assign cursor_vis = (state_q == IDLE);
`endif

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Scoreboard bench for vga_text_ctrl: a screen-level model predicts every RAM
// write and the cursor/scroll position; a monitor pops and checks each write.
module tb_vga_text_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [7:0]  ch = 8'h00;
  logic        ram_we;
  logic [11:0] ram_waddr;
  logic [7:0]  ram_wdata;
  logic [4:0]  scroll_row, cur_row;
  logic [5:0]  cur_col;
  logic        cursor_vis;

  always #5 clk = ~clk;

  vga_text_ctrl dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .ch(ch),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .scroll_row(scroll_row), .cur_row(cur_row), .cur_col(cur_col), .cursor_vis(cursor_vis)
  );

  typedef struct packed { logic [11:0] a; logic [7:0] d; } wr_t;
  wr_t exp_q[$];
  int n_cmp = 0, n_bad = 0, wr_seen = 0;
  int m_scroll = 0, m_row = 0, m_col = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every RAM write must be the next one predicted, with the port busy.
  always @(negedge clk) begin
    if (rst_n && ram_we) begin
      wr_t e;
      wr_seen++;
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", ram_waddr, ram_wdata);
      end else begin
        e = exp_q.pop_front();
        check("ram_write{rdy,vis,addr,data}", {10'd0, wr_ready, cursor_vis, ram_waddr, ram_wdata},
              {10'd0, 2'b00, e.a, e.d});
      end
    end
  end

  // ---------------- screen model ----------------
  function automatic int phys(input int r);
    return (m_scroll + r) % 30;
  endfunction

  task automatic push_wr(input int a, input logic [7:0] d);
    wr_t e;
    e.a = 12'(a); e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic push_clear_all();
    for (int i = 0; i < 1920; i++) push_wr(i, 8'h20);
  endtask

  task automatic newline();
    m_col = 0;
    if (m_row < 29) m_row++;
    else begin
      for (int i = 0; i < 64; i++) push_wr(m_scroll * 64 + i, 8'h20);
      m_scroll = (m_scroll + 1) % 30;
    end
  endtask

  task automatic model(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_wr(phys(m_row) * 64 + m_col, b);
      m_col++;
      if (m_col == 64) newline();
    end else if (b == 8'h0A) newline();
    else if (b == 8'h0D) m_col = 0;
    else if (b == 8'h08) begin
      if (m_col > 0 || m_row > 0) begin
        if (m_col > 0) m_col--;
        else begin m_row--; m_col = 63; end
        push_wr(phys(m_row) * 64 + m_col, 8'h20);
      end
    end else if (b == 8'h0C) begin
      push_clear_all();
      m_row = 0; m_col = 0; m_scroll = 0;
    end
  endtask

  // ---------------- stimulus helpers (entered at a negedge) ----------------
  task automatic wait_ready(input int budget);
    int n = 0;
    while (!wr_ready && n < budget) begin
      wr_valid = 1'($urandom_range(0, 1));   // junk offered while busy
      ch = 8'($urandom);
      @(negedge clk); n++;
    end
    wr_valid = 1'b0;
    if (!wr_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_ready: wr_ready low after %0d cycles", budget);
    end
  endtask

  task automatic send(input logic [7:0] b);
    wait_ready(2500);
    if (wr_ready) begin
      wr_valid = 1'b1; ch = b;
      @(posedge clk);
      model(b);
      @(negedge clk);
      wr_valid = 1'b0; ch = 8'($urandom);
    end
  endtask

  // Printable byte without wrap: write visible one cycle after, ready two after.
  task automatic send_timed(input logic [7:0] b);
    send(b);
    check("lat_n1{we,rdy}", {30'd0, ram_we, wr_ready}, 32'b10);
    @(negedge clk);
    check("lat_n2{we,rdy}", {30'd0, ram_we, wr_ready}, 32'b01);
  endtask

  task automatic check_cursor();
    wait_ready(2500);
    check("cursor{vis,scroll,row,col}", {16'd0, cursor_vis, scroll_row, cur_row, cur_col},
          {16'd0, 1'b1, 5'(m_scroll), 5'(m_row), 6'(m_col)});
    check("pending_writes", exp_q.size(), 0);
  endtask

  function automatic logic [7:0] rnd_print();
    return 8'($urandom_range(32, 126));
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    logic [7:0] b;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst{we,rdy,vis}", {29'd0, ram_we, wr_ready, cursor_vis}, 0);
    check("rst_waddr", ram_waddr, 0);
    check("rst_wdata", ram_wdata, 32'h20);
    check("rst_pos", {scroll_row, cur_row, cur_col}, 0);
    push_clear_all();
    rst_n = 1'b1;
    check_cursor();

    // 'A' at (3,5), scroll 0 -> addr 197
    repeat (3) send(8'h0A);
    repeat (5) send(rnd_print());
    send_timed(8'h41);
    check_cursor();
    check("a_col", cur_col, 6);

    // 64 printables from (29,0): last one wraps and scrolls
    send(8'h0D);
    repeat (26) send(8'h0A);
    check_cursor();
    for (int i = 0; i < 64; i++) send(rnd_print());
    check_cursor();
    check("scroll_after_wrap", scroll_row, 1);

    // Reach scroll 29, then climb to row 2 with BS/CR pairs; 'Z' lands in phys row 1
    repeat (28) send(8'h0A);
    check_cursor();
    repeat (27) begin send(8'h08); send(8'h0D); end
    check_cursor();
    send_timed(8'h5A);
    check_cursor();

    // Backspace from (4,0) -> (3,63)
    send(8'h0D); send(8'h0A); send(8'h0A);
    send(8'h08);
    check_cursor();
    check("bs_pos", {cur_row, cur_col}, {5'd3, 6'd63});

    // scroll_row 7, mid-screen, then form feed
    send(8'h0A);
    repeat (25) send(8'h0A);
    repeat (8) send(8'h0A);
    repeat (10) begin send(8'h08); send(8'h0D); end
    repeat (9) send(rnd_print());
    check_cursor();
    send(8'h0C);
    check_cursor();
    // Backspace at (0,0): no write, no move
    send(8'h08);
    check_cursor();

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 60)      b = rnd_print();
      else if (r < 72) b = 8'h0A;
      else if (r < 77) b = 8'h0D;
      else if (r < 87) b = 8'h08;
      else if (r < 93) b = 8'($urandom_range(0, 7));
      else             b = 8'($urandom_range(127, 255));
      send(b);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (i % 8 == 7) check_cursor();
    end
    check_cursor();

    // Form feed interrupted by reset at write 500: clear restarts from 0
    wait_ready(2500);
    wr_valid = 1'b1; ch = 8'h0C;
    @(posedge clk);
    model(8'h0C);
    #1 wr_valid = 1'b0;
    base = wr_seen;
    n = 0;
    while (wr_seen < base + 500 && n < 3000) begin @(posedge clk); n++; end
    check("writes_before_reset", wr_seen - base, 500);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("rst2{we,rdy,vis}", {29'd0, ram_we, wr_ready, cursor_vis}, 0);
    check("rst2_waddr", ram_waddr, 0);
    exp_q.delete();
    push_clear_all();
    m_row = 0; m_col = 0; m_scroll = 0;
    rst_n = 1'b1;
    check_cursor();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
